alu_operand_stage: RTL
======================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/data width in bits.
REQ-002 Parameter NFWD, default 2, number of forwarding sources; index 0 = youngest, highest priority.
REQ-003 Parameter CNTW, default 16, stall-counter width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream operand bundle valid.
REQ-007 in_ready  out  1  stage can accept bundle this cycle.
REQ-008 rs1_addr, rs2_addr  in  5 each  source register indices.
REQ-009 rs1_val, rs2_val  in  XLEN each  register-bank read data.
REQ-010 imm_val, pc_val  in  XLEN each  immediate and instruction PC.
REQ-011 asel  in  2  operand A source: 0 rs1, 1 pc, 2 zero, 3 zero.
REQ-012 bsel  in  2  operand B source: 0 rs2, 1 imm, 2 constant 4, 3 zero.
REQ-013 fwd_valid  in  NFWD  forwarding source i carries a pending write.
REQ-014 fwd_busy  in  NFWD  source i result not yet available (load in flight).
REQ-015 fwd_rd  in  5*NFWD  destination index of source i, slice [5i+4:5i].
REQ-016 fwd_data  in  XLEN*NFWD  result of source i, slice [XLEN*i+XLEN-1:XLEN*i].
REQ-017 flush  in  1  synchronous kill of held and incoming bundle.
REQ-018 out_valid  out  1  registered bundle valid.
REQ-019 out_ready  in  1  downstream (ALU) accepts bundle.
REQ-020 op_a, op_b, store_data  out  XLEN each  registered ALU operands and forwarded rs2.
REQ-021 fwd_hit_a, fwd_hit_b  out  1 each  registered flags: rs1/rs2 value came from forwarding.
REQ-022 stall_cnt  out  CNTW  saturating count of hazard-stall cycles.

Function
REQ-023 Forward match for rsX: fwd_valid[i] and fwd_rd slice == rsX_addr and rsX_addr != 0; lowest matching i wins; no match -> register-bank value.
REQ-024 rsX_addr == 0 shall always yield zero resolved value, regardless of rsX_val or forwarding.
REQ-025 Hazard: in_valid and winning match for rs1 (asel==0) or rs2 (any bsel, since store_data uses rs2) has fwd_busy set; a busy lower-priority match behind a non-busy winner is no hazard.
REQ-026 in_ready = (!out_valid || out_ready) && !hazard; combinational, no dependence on out_ready beyond this term.
REQ-027 Accept = in_valid && in_ready && !flush; on accept, op_a/op_b/store_data/fwd_hit_* load next edge, out_valid=1.
REQ-028 op_a: asel 0 resolved rs1, 1 pc_val, 2/3 zero; op_b: bsel 0 resolved rs2, 1 imm_val, 2 value 4, 3 zero; store_data always resolved rs2.
REQ-029 fwd_hit_a set only when asel==0 and rs1 forwarded; fwd_hit_b set when rs2 forwarded (any bsel).
REQ-030 out_valid && out_ready && !accept -> out_valid=0 next edge; outputs data hold unchanged when not accepting.
REQ-031 out_valid && !out_ready -> all outputs hold stable (no change of data while valid and not taken).
REQ-032 flush: out_valid=0 next edge, incoming bundle discarded, dominates accept and hazard; data registers may keep old value.
REQ-033 Latency: exactly one cycle accept-to-out_valid; throughput one bundle per cycle when out_ready held high and no hazard.
REQ-034 stall_cnt increments by 1 each cycle in_valid && hazard && !flush; saturates at 2^CNTW-1, no wrap.
REQ-035 All arithmetic-free; widths exact XLEN, constant 4 zero-extended to XLEN.

Reset
REQ-036 rst_n low asynchronously clears out_valid, op_a, op_b, store_data, fwd_hit_a, fwd_hit_b, stall_cnt to 0, including mid-transfer.
REQ-037 While rst_n low, in_ready driven 0; first accept possible on first rising edge after rst_n deasserts.

Verification
REQ-038 asel=0,bsel=1, rs1=5 val 0x10, imm 0x20, no fwd -> next cycle op_a=0x10, op_b=0x20, out_valid=1, hits 0.
REQ-039 rs1=7, fwd_valid=2'b11, fwd_rd={7,7}, data0=0xAAAA, data1=0xBBBB -> op_a=0xAAAA, fwd_hit_a=1.
REQ-040 rs2=3, bsel=0, source 0 matches with fwd_busy[0]=1 for 3 cycles -> in_ready=0, out_valid stays 0, stall_cnt=3; busy drops -> accept, op_b=fwd_data0.
REQ-041 rs1=0, fwd_rd0=0 valid data 0xFFFF, rs1_val 0x1234 -> op_a=0, fwd_hit_a=0.
REQ-042 out_valid=1, out_ready=0 for 4 cycles with new in_valid -> in_ready=0, outputs stable; flush -> out_valid=0 next edge.
REQ-043 CNTW=2, hazard held 6 cycles -> stall_cnt saturates at 3; rst_n pulse mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
//   Bundles every signal of the operand stage except clk/rst_n.
//   master : the environment (issue logic upstream, ALU downstream,
//            forwarding network)
//   slave  : the operand stage itself
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holding valid keeps its payload stable until the transfer.
//   ready may depend on valid combinationally, but valid never waits on ready.
//
// Signal groups
//   upstream   : in_valid/in_ready, rs1/rs2 addr+val, imm_val, pc_val, asel, bsel
//   forwarding : fwd_valid, fwd_busy, fwd_rd (5 bits/source), fwd_data (XLEN/source)
//   control    : flush
//   downstream : out_valid/out_ready, op_a, op_b, store_data, fwd_hit_a/b
//   status     : stall_cnt
interface alu_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int CNTW = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           rs1_addr;
  logic [4:0]           rs2_addr;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  logic [XLEN-1:0]      imm_val;
  logic [XLEN-1:0]      pc_val;
  logic [1:0]           asel;
  logic [1:0]           bsel;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD-1:0]      fwd_busy;
  logic [5*NFWD-1:0]    fwd_rd;
  logic [XLEN*NFWD-1:0] fwd_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      op_a;
  logic [XLEN-1:0]      op_b;
  logic [XLEN-1:0]      store_data;
  logic                 fwd_hit_a;
  logic                 fwd_hit_b;
  logic [CNTW-1:0]      stall_cnt;

  modport master (
    output in_valid, rs1_addr, rs2_addr, rs1_val, rs2_val, imm_val, pc_val,
           asel, bsel, fwd_valid, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, op_a, op_b, store_data, fwd_hit_a, fwd_hit_b,
           stall_cnt
  );

  modport slave (
    input  in_valid, rs1_addr, rs2_addr, rs1_val, rs2_val, imm_val, pc_val,
           asel, bsel, fwd_valid, fwd_busy, fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, op_a, op_b, store_data, fwd_hit_a, fwd_hit_b,
           stall_cnt
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Resolves rs1/rs2 through a priority forwarding network, selects the ALU
//   operands, and registers them in a one-entry valid/ready pipeline slot.
//   A bundle whose winning forwarding source is still busy (load in flight)
//   is held upstream and counted in a saturating stall counter.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_operand_stage_if.slave (all handshake, operand and status signals)
module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_operand_stage_if.slave  bus
);

  typedef struct packed {
    logic            hit;
    logic            busy;
    logic [XLEN-1:0] data;
  } fwd_res_t;

  // Walk from the oldest source down to source 0 so the youngest match is
  // written last and wins. Register x0 never matches.
  function automatic fwd_res_t fwd_lookup(
    input logic [4:0]           addr,
    input logic [NFWD-1:0]      valid,
    input logic [NFWD-1:0]      busy,
    input logic [5*NFWD-1:0]    rd,
    input logic [XLEN*NFWD-1:0] data
  );
    fwd_res_t r;
    r = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (valid[i] && (rd[5*i +: 5] == addr) && (addr != 5'd0)) begin
        r.hit  = 1'b1;
        r.busy = busy[i];
        r.data = data[XLEN*i +: XLEN];
      end
    end
    return r;
  endfunction

  fwd_res_t        rs1_res;
  fwd_res_t        rs2_res;
  logic [XLEN-1:0] rs1_resolved;
  logic [XLEN-1:0] rs2_resolved;
  logic [XLEN-1:0] op_a_sel;
  logic [XLEN-1:0] op_b_sel;
  logic            hazard;
  logic            in_ready;
  logic            accept;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic            fwd_hit_a_q, fwd_hit_a_d;
  logic            fwd_hit_b_q, fwd_hit_b_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    rs1_res = fwd_lookup(bus.rs1_addr, bus.fwd_valid, bus.fwd_busy, bus.fwd_rd, bus.fwd_data);
    rs2_res = fwd_lookup(bus.rs2_addr, bus.fwd_valid, bus.fwd_busy, bus.fwd_rd, bus.fwd_data);

    rs1_resolved = '0;
    if (bus.rs1_addr != 5'd0) rs1_resolved = rs1_res.hit ? rs1_res.data : bus.rs1_val;
    rs2_resolved = '0;
    if (bus.rs2_addr != 5'd0) rs2_resolved = rs2_res.hit ? rs2_res.data : bus.rs2_val;

    unique case (bus.asel)
      2'd0:    op_a_sel = rs1_resolved;
      2'd1:    op_a_sel = bus.pc_val;
      default: op_a_sel = '0;
    endcase

    unique case (bus.bsel)
      2'd0:    op_b_sel = rs2_resolved;
      2'd1:    op_b_sel = bus.imm_val;
      2'd2:    op_b_sel = XLEN'(4);
      default: op_b_sel = '0;
    endcase

    // rs1 only matters when it feeds op_a; rs2 always matters because it
    // also travels as store_data. Only the winning source's busy bit counts.
    hazard = bus.in_valid && (((bus.asel == 2'd0) && rs1_res.busy) || rs2_res.busy);

    // Held low during reset so nothing is accepted before the first edge
    // after release.
    in_ready = rst_n && (!out_valid_q || bus.out_ready) && !hazard;
    accept   = bus.in_valid && in_ready && !bus.flush;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    fwd_hit_a_d  = fwd_hit_a_q;
    fwd_hit_b_d  = fwd_hit_b_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      op_a_d       = op_a_sel;
      op_b_d       = op_b_sel;
      store_data_d = rs2_resolved;
      fwd_hit_a_d  = (bus.asel == 2'd0) && rs1_res.hit;
      fwd_hit_b_d  = rs2_res.hit;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (hazard && !bus.flush && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
      fwd_hit_a_q  <= 1'b0;
      fwd_hit_b_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
      fwd_hit_a_q  <= fwd_hit_a_d;
      fwd_hit_b_q  <= fwd_hit_b_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.store_data = store_data_q;
  assign bus.fwd_hit_a  = fwd_hit_a_q;
  assign bus.fwd_hit_b  = fwd_hit_b_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule
